// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: D-stage stall/flush decisions plus an MDU busy tracker.
// Define CTRL_PERF_CNT_EN to add the saturating stall_cnt performance counter.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic [4:0]  E_wa,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  E_tnew,
  input  logic [1:0]  M_tnew,
  input  logic        D_is_md,
  input  logic        D_is_eret,
  input  logic        E_mtc0_epc,
  input  logic        M_mtc0_epc,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  input  logic        int_req,
  output logic        F_en,
  output logic        D_en,
  output logic        E_flush,
  output logic        Req,
  output logic        md_busy,
  output logic        stall
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  md_state_e  state_q;
  logic [3:0] cnt_q;
  logic       md_busy_q;

  logic rs_hazard;
  logic rt_hazard;
  logic md_hazard;
  logic eret_hazard;

  // A tuse of 3 (operand unused) can never be exceeded by a 2-bit tnew.
  assign rs_hazard = (D_rs_addr != 5'd0) &&
                     (((D_rs_addr == E_wa) && (E_tnew > D_rs_tuse)) ||
                      ((D_rs_addr == M_wa) && (M_tnew > D_rs_tuse)));
  assign rt_hazard = (D_rt_addr != 5'd0) &&
                     (((D_rt_addr == E_wa) && (E_tnew > D_rt_tuse)) ||
                      ((D_rt_addr == M_wa) && (M_tnew > D_rt_tuse)));
  assign md_hazard   = D_is_md && (md_busy_q || E_md_start);
  assign eret_hazard = D_is_eret && (E_mtc0_epc || M_mtc0_epc);

  assign stall   = rs_hazard | rt_hazard | md_hazard | eret_hazard;
  assign Req     = int_req;
  assign md_busy = md_busy_q;

  // An exception flush always wins over a stall so the handler can be fetched.
  assign F_en    = Req | ~stall;
  assign D_en    = Req | ~stall;
  assign E_flush = ~Req & stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      md_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A start alongside int_req belongs to a squashed instruction.
          if (E_md_start && !int_req) begin
            state_q   <= BUSY;
            cnt_q     <= E_md_is_div ? 4'd10 : 4'd5;
            md_busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd1) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            md_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= 4'd0;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !Req && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle model comparison plus literal checks.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
  logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic        D_is_md, D_is_eret, E_mtc0_epc, M_mtc0_epc;
  logic        E_md_start, E_md_is_div, int_req;
  logic        F_en, D_en, E_flush, Req, md_busy, stall;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  pipe_hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs_addr   (D_rs_addr),
    .D_rt_addr   (D_rt_addr),
    .D_rs_tuse   (D_rs_tuse),
    .D_rt_tuse   (D_rt_tuse),
    .E_wa        (E_wa),
    .M_wa        (M_wa),
    .E_tnew      (E_tnew),
    .M_tnew      (M_tnew),
    .D_is_md     (D_is_md),
    .D_is_eret   (D_is_eret),
    .E_mtc0_epc  (E_mtc0_epc),
    .M_mtc0_epc  (M_mtc0_epc),
    .E_md_start  (E_md_start),
    .E_md_is_div (E_md_is_div),
    .int_req     (int_req),
    .F_en        (F_en),
    .D_en        (D_en),
    .E_flush     (E_flush),
    .Req         (Req),
    .md_busy     (md_busy),
    .stall       (stall)
`ifdef CTRL_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  // Model: remaining MDU busy cycles as a plain integer, stall count as a wide integer.
  int      mdl_left = 0;
  longint  mdl_scnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic bit src_hazard(input logic [4:0] a, input logic [1:0] tuse);
    bit h;
    h = 1'b0;
    if (a != 5'd0) begin
      if (a == E_wa && int'(E_tnew) > int'(tuse)) h = 1'b1;
      if (a == M_wa && int'(M_tnew) > int'(tuse)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic bit exp_stall();
    bit s;
    s = src_hazard(D_rs_addr, D_rs_tuse) || src_hazard(D_rt_addr, D_rt_tuse);
    if (D_is_md && (mdl_left > 0 || E_md_start)) s = 1'b1;
    if (D_is_eret && (E_mtc0_epc || M_mtc0_epc)) s = 1'b1;
    return s;
  endfunction

  always @(posedge clk) begin
    bit s;
    s = exp_stall();
    if (reset) begin
      mdl_left = 0;
      mdl_scnt = 0;
    end else begin
      if (s && !int_req && mdl_scnt < 64'hFFFF_FFFF) mdl_scnt = mdl_scnt + 1;
      if (mdl_left > 0) mdl_left = mdl_left - 1;
      else if (E_md_start && !int_req) mdl_left = E_md_is_div ? 10 : 5;
    end
  end

  always @(negedge clk) begin
    bit s;
    if (chk_en) begin
      s = exp_stall();
      chk("stall",   {31'd0, stall},   {31'd0, s});
      chk("Req",     {31'd0, Req},     {31'd0, int_req});
      chk("F_en",    {31'd0, F_en},    {31'd0, int_req | ~s});
      chk("D_en",    {31'd0, D_en},    {31'd0, int_req | ~s});
      chk("E_flush", {31'd0, E_flush}, {31'd0, ~int_req & s});
      chk("md_busy", {31'd0, md_busy}, {31'd0, mdl_left > 0});
`ifdef CTRL_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, mdl_scnt[31:0]);
`endif
    end
  end

  task automatic clear();
    D_rs_addr = 0; D_rt_addr = 0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
    E_wa = 0; M_wa = 0; E_tnew = 0; M_tnew = 0;
    D_is_md = 0; D_is_eret = 0; E_mtc0_epc = 0; M_mtc0_epc = 0;
    E_md_start = 0; E_md_is_div = 0; int_req = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic to_sample();
    @(negedge clk); #1;
  endtask

  initial begin
    int ns, nb;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] sc0;
`endif
    clear();
    reset = 1'b1;
    next();
    chk_en = 1'b1;
    next();
    to_sample();
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
`ifdef CTRL_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    next(); reset = 1'b0;

    // E-stage producer hazard on rs, then the same with $zero
    next(); clear(); E_wa = 5; E_tnew = 2; D_rs_addr = 5; D_rs_tuse = 1;
    to_sample();
    chk("e_rs_stall", {31'd0, stall}, 32'd1);
    chk("e_rs_fen",   {31'd0, F_en}, 32'd0);
    chk("e_rs_den",   {31'd0, D_en}, 32'd0);
    chk("e_rs_flush", {31'd0, E_flush}, 32'd1);
    next(); D_rs_addr = 0;
    to_sample();
    chk("zero_reg_stall", {31'd0, stall}, 32'd0);

    next(); clear(); M_wa = 8; M_tnew = 2; D_rs_addr = 8; D_rs_tuse = 1;
    to_sample();
    chk("m_rs_stall", {31'd0, stall}, 32'd1);

    next(); clear(); M_wa = 8; M_tnew = 1; D_rt_addr = 8; D_rt_tuse = 1;
    to_sample();
    chk("m_rt_nostall", {31'd0, stall}, 32'd0);
    next(); D_rt_tuse = 0;
    to_sample();
    chk("m_rt_tuse0", {31'd0, stall}, 32'd1);

    next(); clear(); E_wa = 3; E_tnew = 3; D_rt_addr = 3; D_rt_tuse = 3;
    to_sample();
    chk("unused_src", {31'd0, stall}, 32'd0);
    next(); D_rt_tuse = 2;
    to_sample();
    chk("tnew3_tuse2", {31'd0, stall}, 32'd1);

    // div with D_is_md held: start cycle plus ten busy cycles stall
    next(); clear(); D_is_md = 1; E_md_start = 1; E_md_is_div = 1;
    ns = 0; nb = 0;
    for (int i = 0; i < 14; i++) begin
      to_sample();
      ns += int'(stall); nb += int'(md_busy);
      next(); E_md_start = 0;
    end
    chk("div_busy_cycles", ns == 11 ? 32'd11 : ns, 32'd11);
    chk("div_md_busy", nb, 32'd10);

    // restart during BUSY is ignored
    clear(); E_md_start = 1; E_md_is_div = 1; nb = 0;
    for (int i = 0; i < 14; i++) begin
      to_sample();
      nb += int'(md_busy);
      next(); E_md_start = (i == 3); E_md_is_div = 0;
    end
    chk("no_reload", nb, 32'd10);

    // start squashed by int_req
    clear(); E_md_start = 1; int_req = 1;
    to_sample();
    chk("sq_req",   {31'd0, Req}, 32'd1);
    chk("sq_fen",   {31'd0, F_en}, 32'd1);
    chk("sq_flush", {31'd0, E_flush}, 32'd0);
    next(); clear();
    to_sample();
    chk("sq_md_busy", {31'd0, md_busy}, 32'd0);

    // int_req during a mult does not shorten it
    next(); clear(); E_md_start = 1; nb = 0;
    for (int i = 0; i < 10; i++) begin
      to_sample();
      nb += int'(md_busy);
      next(); E_md_start = 0; int_req = (i == 1 || i == 2);
    end
    chk("mult_int_busy", nb, 32'd5);

    // reset mid-div, with a live rs hazard while reset is high
    clear(); E_md_start = 1; E_md_is_div = 1;
    next(); E_md_start = 0;
    next();
    next(); reset = 1; E_wa = 5; E_tnew = 2; D_rs_addr = 5; D_rs_tuse = 1;
    to_sample();
    chk("rst_comb_stall", {31'd0, stall}, 32'd1);
    next(); reset = 0; clear();
    to_sample();
    chk("rst_div_md_busy", {31'd0, md_busy}, 32'd0);
`ifdef CTRL_PERF_CNT_EN
    chk("rst_div_scnt", stall_cnt, 32'd0);
`endif

    // eret behind mtc0 EPC, then the same stall under int_req
    next(); D_is_eret = 1; M_mtc0_epc = 1;
    to_sample();
    chk("eret_stall", {31'd0, stall}, 32'd1);
    next(); int_req = 1;
    to_sample();
    chk("eret_int_req",   {31'd0, Req}, 32'd1);
    chk("eret_int_fen",   {31'd0, F_en}, 32'd1);
    chk("eret_int_flush", {31'd0, E_flush}, 32'd0);
`ifdef CTRL_PERF_CNT_EN
    chk("eret_scnt_1", stall_cnt, 32'd1);
    sc0 = stall_cnt;
`endif
    next(); clear();
    to_sample();
`ifdef CTRL_PERF_CNT_EN
    chk("eret_scnt_hold", stall_cnt, sc0);
`endif

    // mixed vectors, checked by the per-cycle model
    for (int i = 0; i < 300; i++) begin
      next();
      D_rs_addr   = 5'($urandom_range(0, 3));
      D_rt_addr   = 5'($urandom_range(0, 3));
      D_rs_tuse   = 2'($urandom_range(0, 3));
      D_rt_tuse   = 2'($urandom_range(0, 3));
      E_wa        = 5'($urandom_range(0, 3));
      M_wa        = 5'($urandom_range(0, 3));
      E_tnew      = 2'($urandom_range(0, 3));
      M_tnew      = 2'($urandom_range(0, 3));
      D_is_md     = 1'($urandom_range(0, 1));
      D_is_eret   = ($urandom_range(0, 3) == 0);
      E_mtc0_epc  = ($urandom_range(0, 3) == 0);
      M_mtc0_epc  = ($urandom_range(0, 3) == 0);
      E_md_start  = ($urandom_range(0, 7) == 0);
      E_md_is_div = 1'($urandom_range(0, 1));
      int_req     = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 63) == 0);
    end
    next(); clear(); reset = 0;
    to_sample();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
